// File: rtl/adc_result_pkg.sv
// Shared constants and helpers for the ADC result decimator.
package adc_result_pkg;

    localparam int unsigned DATA_BITS       = 12;
    localparam int unsigned MAX_DEC_LOG2    = 4;
    localparam int unsigned FIFO_DEPTH_LOG2 = 2;
    localparam int unsigned ACC_BITS        = DATA_BITS + MAX_DEC_LOG2;

    localparam logic [2:0] DEC_1X  = 3'd0;
    localparam logic [2:0] DEC_2X  = 3'd1;
    localparam logic [2:0] DEC_4X  = 3'd2;
    localparam logic [2:0] DEC_8X  = 3'd3;
    localparam logic [2:0] DEC_16X = 3'd4;

    function automatic logic [2:0] clamp_dec(input logic [2:0] code, input int unsigned max_log2);
        if (32'(code) > max_log2) begin
            return 3'(max_log2);
        end
        return code;
    endfunction

endpackage

// File: rtl/adc_result_fifo.sv
// Synchronous first-word-fall-through FIFO; output holds the last popped word while empty.
module adc_result_fifo #(
    parameter int unsigned WIDTH      = 12,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      data_in,
    output logic                  full,
    input  logic                  pop,
    output logic [WIDTH-1:0]      data_out,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [Depth];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [WIDTH-1:0]      last_q;
    logic                  do_push;
    logic                  do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (DEPTH_LOG2 + 1)'(Depth));
    assign do_pop   = pop & ~empty;
    // A pop frees the slot the push writes into, so full+push+pop succeeds.
    assign do_push  = push & (~full | do_pop);
    assign data_out = empty ? last_q : mem_q[rd_ptr_q];
    assign count    = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                last_q   <= mem_q[rd_ptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: rtl/adc_result_decimator.sv
// Captures SAR results, averages 2^N of them and queues the averages for bus readout.
module adc_result_decimator #(
    parameter int unsigned DATA_BITS       = adc_result_pkg::DATA_BITS,
    parameter int unsigned MAX_DEC_LOG2    = adc_result_pkg::MAX_DEC_LOG2,
    parameter int unsigned FIFO_DEPTH_LOG2 = adc_result_pkg::FIFO_DEPTH_LOG2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       conv_finished,
    input  logic [DATA_BITS-1:0]       result,
    input  logic [2:0]                 dec_control,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [DATA_BITS-1:0]       rd_data,
    output logic [FIFO_DEPTH_LOG2:0]   rd_count,
    output logic                       overflow,
    input  logic                       clear_overflow
);

    import adc_result_pkg::*;

    localparam int unsigned AccBits = DATA_BITS + MAX_DEC_LOG2;
    localparam logic [MAX_DEC_LOG2:0] One = 1;

    logic                    cf_q;
    logic [AccBits-1:0]      acc_q, acc_d;
    logic [MAX_DEC_LOG2-1:0] win_cnt_q, win_cnt_d;
    logic [2:0]              n_lat_q, n_lat_d;
    logic                    overflow_q, overflow_d;

    logic                    capture;
    logic [2:0]              n_eff;
    logic [MAX_DEC_LOG2:0]   last_idx;
    logic                    win_last;
    logic [AccBits-1:0]      sum;
    logic [DATA_BITS-1:0]    word;
    logic                    push;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;

    assign capture  = conv_finished & ~cf_q;
    // The first capture of a window uses the live control code; later ones use the latched one.
    assign n_eff    = (win_cnt_q == '0) ? clamp_dec(dec_control, MAX_DEC_LOG2) : n_lat_q;
    assign last_idx = (One << n_eff) - One;
    assign win_last = ({1'b0, win_cnt_q} == last_idx);
    assign sum      = acc_q + AccBits'(result);
    assign word     = DATA_BITS'(sum >> n_eff);
    assign push     = capture & win_last;
    assign pop      = rd_ready & ~fifo_empty;
    assign rd_valid = ~fifo_empty;
    assign overflow = overflow_q;

    always_comb begin
        acc_d      = acc_q;
        win_cnt_d  = win_cnt_q;
        n_lat_d    = n_lat_q;
        overflow_d = overflow_q;
        if (capture) begin
            if (win_cnt_q == '0) begin
                n_lat_d = n_eff;
            end
            if (win_last) begin
                acc_d     = '0;
                win_cnt_d = '0;
            end else begin
                acc_d     = sum;
                win_cnt_d = win_cnt_q + 1'b1;
            end
        end
        if (clear_overflow) begin
            overflow_d = 1'b0;
        end
        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cf_q       <= 1'b0;
            acc_q      <= '0;
            win_cnt_q  <= '0;
            n_lat_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            cf_q       <= conv_finished;
            acc_q      <= acc_d;
            win_cnt_q  <= win_cnt_d;
            n_lat_q    <= n_lat_d;
            overflow_q <= overflow_d;
        end
    end

    adc_result_fifo #(
        .WIDTH      (DATA_BITS),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .data_in  (word),
        .full     (fifo_full),
        .pop      (pop),
        .data_out (rd_data),
        .empty    (fifo_empty),
        .count    (rd_count)
    );

endmodule
